// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch front end.
// Optional feature macro: FETCH_MISALIGN_FAULT_EN (misaligned redirect -> FAULT).
package fetch_unit_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // One buffered instruction word together with the PC it was fetched from.
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_s;

    // FAULT is only ever entered when FETCH_MISALIGN_FAULT_EN is defined.
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        FAULT = 2'd2
    } fetch_state_e;

    // Word-align a PC by clearing its two low bits.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Request/response/decode/redirect bundle of the fetch unit.
// Optional feature macro (consumed by fetch_unit): FETCH_MISALIGN_FAULT_EN.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic            o_imem_req_valid;
    logic            i_imem_req_ready;
    logic [XLEN-1:0] o_imem_addr;
    logic            i_imem_rsp_valid;
    logic [XLEN-1:0] i_imem_rsp_data;
    logic            o_instr_valid;
    logic            i_instr_ready;
    logic [XLEN-1:0] o_instruction;
    logic [XLEN-1:0] o_pc;
    logic            i_redirect_valid;
    logic [XLEN-1:0] i_redirect_pc;
    logic            o_fetch_fault;

    // Fetch unit side.
    modport master (
        output o_imem_req_valid, o_imem_addr, o_instr_valid, o_instruction, o_pc, o_fetch_fault,
        input  i_imem_req_ready, i_imem_rsp_valid, i_imem_rsp_data, i_instr_ready,
               i_redirect_valid, i_redirect_pc
    );

    // Memory / decode / branch-resolution side.
    modport slave (
        input  o_imem_req_valid, o_imem_addr, o_instr_valid, o_instruction, o_pc, o_fetch_fault,
        output i_imem_req_ready, i_imem_rsp_valid, i_imem_rsp_data, i_instr_ready,
               i_redirect_valid, i_redirect_pc
    );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer of fetch_entry_s; flush wins over push/pop.
// Optional feature macro (consumed by fetch_unit): FETCH_MISALIGN_FAULT_EN.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  fetch_entry_s i_din,
    output fetch_entry_s o_head,
    output logic [CW-1:0] o_count,
    output logic         o_full,
    output logic         o_empty
);

    fetch_entry_s  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // A push into a full buffer is legal only when the head leaves the same cycle.
    assign do_push = i_push && (!o_full || i_pop);
    assign do_pop  = i_pop && !o_empty;

    // Storage and pointers; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (i_flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_count <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= i_din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            o_count <= o_count + CW'(do_push) - CW'(do_pop);
        end
    end

    assign o_head  = mem[rd_ptr];
    assign o_empty = (o_count == '0);
    assign o_full  = (o_count == CW'(DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC generation, credit-limited memory requests,
// instruction buffering and redirect handling with stale-response discard.
// Optional feature macro: FETCH_MISALIGN_FAULT_EN (misaligned redirect enters a
// sticky FAULT state until an aligned redirect arrives).
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    fetch_unit_if.master  bus
);

    localparam int           CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0]  DEPTH_W = (CW + 1)'(FIFO_DEPTH);

    fetch_state_e    state_q, state_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic [CW-1:0]   outstanding_q;
    logic [CW-1:0]   fifo_count;
    logic [CW:0]     in_use;
    logic [XLEN-1:0] fetch_pc_q;
    logic [XLEN-1:0] rsp_pc_q;
    logic [XLEN-1:0] redirect_pc;
    logic            misalign;
    logic            req_valid, instr_valid;
    logic            req_fire, push, pop, flush;
    logic            fifo_full, fifo_empty;
    fetch_entry_s    head;

    assign redirect_pc = align_pc(bus.i_redirect_pc);

`ifdef FETCH_MISALIGN_FAULT_EN
    assign misalign = bus.i_redirect_valid && (bus.i_redirect_pc != redirect_pc);
`else
    assign misalign = 1'b0;
`endif

    // Slots already promised: words in flight plus words buffered.
    assign in_use = {1'b0, outstanding_q} + {1'b0, fifo_count};

    // State register: FSM state and the count of stale responses still to drop.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= RUN;
            discard_q <= '0;
        end else begin
            state_q   <= state_d;
            discard_q <= discard_d;
        end
    end

    // Next state: a redirect re-arms the discard count from what is still in flight.
    always_comb begin
        discard_d = discard_q;
        state_d   = state_q;
        if (bus.i_redirect_valid)
            discard_d = outstanding_q - CW'(bus.i_imem_rsp_valid);
        else if (bus.i_imem_rsp_valid && discard_q != '0)
            discard_d = discard_q - CW'(1);

        if (misalign)
            state_d = FAULT;
        else if (bus.i_redirect_valid || state_q != FAULT)
            state_d = (discard_d != '0) ? DRAIN : RUN;
    end

    // Outputs and handshakes; everything is held quiet while reset is asserted.
    always_comb begin
        req_valid   = i_rst_n && (state_q != FAULT) && !bus.i_redirect_valid && (in_use < DEPTH_W);
        instr_valid = !fifo_empty && !bus.i_redirect_valid && (state_q != FAULT);
        req_fire    = req_valid && bus.i_imem_req_ready;
        pop         = instr_valid && bus.i_instr_ready;
        flush       = bus.i_redirect_valid;
        push        = bus.i_imem_rsp_valid && !bus.i_redirect_valid && (discard_q == '0)
                      && (!fifo_full || pop);

        bus.o_imem_req_valid = req_valid;
        bus.o_imem_addr      = i_rst_n ? fetch_pc_q : '0;
        bus.o_instr_valid    = instr_valid;
        bus.o_instruction    = head.instr;
        bus.o_pc             = head.pc;
`ifdef FETCH_MISALIGN_FAULT_EN
        bus.o_fetch_fault    = (state_q == FAULT);
`else
        bus.o_fetch_fault    = 1'b0;
`endif
    end

    // Fetch PC, response PC and in-flight counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
        end else begin
            outstanding_q <= outstanding_q + CW'(req_fire) - CW'(bus.i_imem_rsp_valid);
            if (bus.i_redirect_valid) begin
                fetch_pc_q <= redirect_pc;
                rsp_pc_q   <= redirect_pc;
            end else begin
                if (req_fire) fetch_pc_q <= fetch_pc_q + XLEN'(4);
                if (push)     rsp_pc_q   <= rsp_pc_q + XLEN'(4);
            end
        end
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (push),
        .i_pop   (pop),
        .i_flush (flush),
        .i_din   ('{instr: bus.i_imem_rsp_data, pc: rsp_pc_q}),
        .o_head  (head),
        .o_count (fifo_count),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a cycle table for warm-up streaming and
// backpressure, then hand-written redirect / flush / wrap / misalign sequences
// driven by a small in-order memory model (data = addr ^ A5A5_0000).
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_unit_if bus();

    fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    localparam logic [31:0] XORK = 32'hA5A5_0000;

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [31:0] rd;
        logic        ir;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_pc;
        logic [31:0] e_ins;
    } vec_t;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] mq[$];
    bit          rsp_en;
    logic [31:0] exp_pc;
    int          npop, nfire;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.i_imem_req_ready = 1'b1;
        bus.i_imem_rsp_valid = 1'b0;
        bus.i_imem_rsp_data  = '0;
        bus.i_instr_ready    = 1'b1;
        bus.i_redirect_valid = 1'b0;
        bus.i_redirect_pc    = '0;
        mq.delete();
        rsp_en = 1'b1;
        exp_pc = 32'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One call = n cycles; memory answers one queued request per cycle when enabled.
    task automatic run(input int n);
        npop  = 0;
        nfire = 0;
        for (int c = 0; c < n; c++) begin
            if (rsp_en && mq.size() > 0) begin
                bus.i_imem_rsp_valid = 1'b1;
                bus.i_imem_rsp_data  = mq.pop_front() ^ XORK;
            end else begin
                bus.i_imem_rsp_valid = 1'b0;
                bus.i_imem_rsp_data  = '0;
            end
            #1;
            if (bus.i_redirect_valid) begin
                chk("redir_req_valid", 32'(bus.o_imem_req_valid), 32'd0);
                chk("redir_instr_valid", 32'(bus.o_instr_valid), 32'd0);
            end
            if (bus.o_instr_valid && bus.i_instr_ready) begin
                chk("pop_pc", bus.o_pc, exp_pc);
                chk("pop_instr", bus.o_instruction, exp_pc ^ XORK);
                exp_pc += 32'd4;
                npop++;
            end
            if (bus.o_imem_req_valid && bus.i_imem_req_ready) begin
                mq.push_back(bus.o_imem_addr);
                nfire++;
            end
            @(negedge clk);
        end
        bus.i_imem_rsp_valid = 1'b0;
        bus.i_redirect_valid = 1'b0;
    endtask

    task automatic redirect_cycle(input logic [31:0] pc);
        bus.i_redirect_valid = 1'b1;
        bus.i_redirect_pc    = pc;
        run(1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vt[12];
        //          rdy rv  rd             ir  req addr          iv  pc            ins
        vt[0]  = '{1, 0, 32'h0,         1,  1, 32'h00,        0,  32'h0,  32'h0};
        vt[1]  = '{1, 1, 32'hA5A5_0000, 1,  1, 32'h04,        0,  32'h0,  32'h0};
        vt[2]  = '{1, 1, 32'hA5A5_0004, 1,  0, 32'h08,        1,  32'h0,  32'hA5A5_0000};
        vt[3]  = '{1, 0, 32'h0,         1,  1, 32'h08,        1,  32'h4,  32'hA5A5_0004};
        vt[4]  = '{1, 1, 32'hA5A5_0008, 1,  1, 32'h0C,        0,  32'h0,  32'h0};
        vt[5]  = '{1, 1, 32'hA5A5_000C, 1,  0, 32'h10,        1,  32'h8,  32'hA5A5_0008};
        vt[6]  = '{1, 0, 32'h0,         1,  1, 32'h10,        1,  32'hC,  32'hA5A5_000C};
        vt[7]  = '{1, 1, 32'hA5A5_0010, 0,  1, 32'h14,        0,  32'h0,  32'h0};
        vt[8]  = '{1, 1, 32'hA5A5_0014, 0,  0, 32'h18,        1,  32'h10, 32'hA5A5_0010};
        vt[9]  = '{1, 0, 32'h0,         0,  0, 32'h18,        1,  32'h10, 32'hA5A5_0010};
        vt[10] = '{1, 0, 32'h0,         1,  0, 32'h18,        1,  32'h10, 32'hA5A5_0010};
        vt[11] = '{1, 0, 32'h0,         1,  1, 32'h18,        1,  32'h14, 32'hA5A5_0014};

        // Outputs quiet during reset.
        bus.i_imem_req_ready = 1'b1;
        bus.i_imem_rsp_valid = 1'b0;
        bus.i_imem_rsp_data  = '0;
        bus.i_instr_ready    = 1'b1;
        bus.i_redirect_valid = 1'b0;
        bus.i_redirect_pc    = '0;
        #2;
        chk("rst_req_valid", 32'(bus.o_imem_req_valid), 32'd0);
        chk("rst_addr", bus.o_imem_addr, 32'd0);
        chk("rst_instr_valid", 32'(bus.o_instr_valid), 32'd0);
        chk("rst_instruction", bus.o_instruction, 32'd0);
        chk("rst_pc", bus.o_pc, 32'd0);
        chk("rst_fault", 32'(bus.o_fetch_fault), 32'd0);

        // Table: warm-up streaming then a short decode stall.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            bus.i_imem_req_ready = vt[i].rdy;
            bus.i_imem_rsp_valid = vt[i].rv;
            bus.i_imem_rsp_data  = vt[i].rd;
            bus.i_instr_ready    = vt[i].ir;
            #1;
            chk($sformatf("vec%0d_req_valid", i), 32'(bus.o_imem_req_valid), 32'(vt[i].e_req));
            chk($sformatf("vec%0d_addr", i), bus.o_imem_addr, vt[i].e_addr);
            chk($sformatf("vec%0d_instr_valid", i), 32'(bus.o_instr_valid), 32'(vt[i].e_iv));
            if (vt[i].e_iv) begin
                chk($sformatf("vec%0d_pc", i), bus.o_pc, vt[i].e_pc);
                chk($sformatf("vec%0d_instr", i), bus.o_instruction, vt[i].e_ins);
            end
            @(negedge clk);
        end
        bus.i_imem_rsp_valid = 1'b0;

        // Backpressure: decode stalled 10 cycles, then released.
        do_reset();
        bus.i_instr_ready = 1'b0;
        run(10);
        chk("bp_fires", 32'(nfire), 32'd2);
        #1;
        chk("bp_req_valid_low", 32'(bus.o_imem_req_valid), 32'd0);
        chk("bp_head_pc", bus.o_pc, 32'h0);
        bus.i_instr_ready = 1'b1;
        run(30);
        chk("bp_pops_ge15", 32'(npop >= 15), 32'd1);

        // Redirect with two requests outstanding.
        do_reset();
        rsp_en = 1'b0;
        run(3);
        chk("r2_fires", 32'(nfire), 32'd2);
        #1;
        chk("r2_credit_stall", 32'(bus.o_imem_req_valid), 32'd0);
        redirect_cycle(32'h100);
        rsp_en = 1'b1;
        exp_pc = 32'h100;
        run(20);
        chk("r2_pops_ge5", 32'(npop >= 5), 32'd1);

        // Redirect flushes a full buffer.
        do_reset();
        bus.i_instr_ready = 1'b0;
        run(6);
        #1;
        chk("fl_full_valid", 32'(bus.o_instr_valid), 32'd1);
        bus.i_instr_ready = 1'b1;
        redirect_cycle(32'h300);
        #1;
        chk("fl_empty_after", 32'(bus.o_instr_valid), 32'd0);
        chk("fl_req_valid", 32'(bus.o_imem_req_valid), 32'd1);
        chk("fl_addr", bus.o_imem_addr, 32'h300);
        exp_pc = 32'h300;
        run(15);
        chk("fl_pops_ge3", 32'(npop >= 3), 32'd1);

        // Redirect coincident with the only outstanding response.
        do_reset();
        rsp_en = 1'b0;
        run(1);
        bus.i_imem_req_ready = 1'b0;
        rsp_en = 1'b1;
        redirect_cycle(32'h200);
        bus.i_imem_req_ready = 1'b1;
        #1;
        chk("rs_dropped", 32'(bus.o_instr_valid), 32'd0);
        chk("rs_addr", bus.o_imem_addr, 32'h200);
        exp_pc = 32'h200;
        run(15);
        chk("rs_pops_ge3", 32'(npop >= 3), 32'd1);

        // PC wrap at the top of the address space.
        do_reset();
        run(4);
        redirect_cycle(32'hFFFF_FFF8);
        exp_pc = 32'hFFFF_FFF8;
        run(15);
        chk("wrap_pops_ge5", 32'(npop >= 5), 32'd1);

        // Misaligned redirect.
        do_reset();
        run(4);
        redirect_cycle(32'h102);
        #1;
`ifdef FETCH_MISALIGN_FAULT_EN
        chk("mis_fault_set", 32'(bus.o_fetch_fault), 32'd1);
        run(6);
        chk("mis_no_req", 32'(nfire), 32'd0);
        chk("mis_no_pop", 32'(npop), 32'd0);
        #1;
        chk("mis_fault_sticky", 32'(bus.o_fetch_fault), 32'd1);
        redirect_cycle(32'h200);
        #1;
        chk("mis_fault_clr", 32'(bus.o_fetch_fault), 32'd0);
        exp_pc = 32'h200;
`else
        chk("mis_fault_tied", 32'(bus.o_fetch_fault), 32'd0);
        exp_pc = 32'h100;
`endif
        run(15);
        chk("mis_pops_ge3", 32'(npop >= 3), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch front end that produces the 32-bit instruction words consumed by decoder_logic.
- Maintains the fetch PC and issues in-order word requests to instruction memory over a valid/ready request channel.
- Buffers returned words with their PCs in a small FIFO and presents them to decode over a valid/ready handshake.
- Handles redirects from branch/jump resolution by flushing buffered words and discarding stale in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, PC of the first fetch after reset.
- FIFO_DEPTH, 2, number of instruction buffer entries; power of two, at least 2.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- o_imem_req_valid  output  1  fetch request valid.
- i_imem_req_ready  input  1  memory accepts request; fire = valid && ready.
- o_imem_addr  output  XLEN  word-aligned fetch address.
- i_imem_rsp_valid  input  1  response valid; in order, always accepted, no backpressure.
- i_imem_rsp_data  input  XLEN  returned instruction word.
- o_instr_valid  output  1  FIFO head valid toward decode.
- i_instr_ready  input  1  decode consumes the head; pop = valid && ready.
- o_instruction  output  XLEN  head instruction; drives decoder_logic i_instruction.
- o_pc  output  XLEN  PC of the head instruction.
- i_redirect_valid  input  1  redirect request, single-cycle pulse.
- i_redirect_pc  input  XLEN  redirect target.
- o_fetch_fault  output  1  misaligned redirect; only with the optional feature, tie 0 otherwise.

Behaviour:
- Reset: fetch_pc=RESET_PC, FIFO empty, outstanding=0, discard_cnt=0, state RUN. All outputs 0 while i_rst_n=0.
- First cycle after reset release: o_imem_req_valid=1, o_imem_addr=RESET_PC.
- Credit rule: o_imem_req_valid = state!=FAULT && !i_redirect_valid && (outstanding + fifo_count) < FIFO_DEPTH. This guarantees every response has a free slot.
- On request fire: fetch_pc += 4, wrapping modulo 2^XLEN (FFFF_FFFC wraps to 0000_0000); outstanding increments.
- On response: outstanding decrements.
  - discard_cnt > 0: the word is dropped and discard_cnt decrements.
  - otherwise: push {data, pc}. The pc comes from a response-PC register that starts at RESET_PC or the redirect target and increments by 4 per accepted response.
- Output timing: o_instruction/o_pc/o_instr_valid come from the FIFO head, registered. Minimum latency is rsp_valid to o_instr_valid = 1 cycle.
- Simultaneous push and pop: allowed, including when the FIFO is full and a pop frees the slot.
- Redirect cycle:
  - No request is issued; the FIFO is cleared.
  - Any pop in that cycle is ignored (o_instr_valid is forced 0).
  - Any response in that cycle is discarded.
  - discard_cnt <= outstanding - (i_imem_rsp_valid ? 1 : 0).
  - fetch_pc and response-PC <= i_redirect_pc with bits [1:0] forced 0.
  - The next cycle may issue at the target.
- States:
  - RUN: discard_cnt==0.
  - DRAIN: discard_cnt>0. Requests are still permitted; new responses are accepted normally once the count reaches 0. Back to RUN when discard_cnt reaches 0.
  - FAULT: exists only with the optional feature.
- Redirect while in DRAIN: discard_cnt is recomputed per the rule above, replacing the old count.
- Reset mid-operation: all state clears immediately. Responses to pre-reset requests are not expected; memory is reset together with this block.

Optional Feature:
- Macro: FETCH_MISALIGN_FAULT_EN.
- Defined: a redirect with pc[1:0] != 0 enters FAULT.
  - FIFO flushed; discard rule applied; o_fetch_fault=1 (sticky).
  - No requests issued, o_instr_valid=0.
  - An aligned redirect clears the fault and resumes in RUN/DRAIN.
- Undefined: bits [1:0] are silently zeroed; the FAULT state is absent; o_fetch_fault is tied 0.

Decomposition:
- rapid_pkg additions:
  - fetch_entry_s typedef {instr [XLEN-1:0], pc [XLEN-1:0]}.
  - RESET_PC_DEFAULT constant.
  - fetch_state_e enum {RUN, DRAIN, FAULT}.
- One natural sub-module, fetch_fifo: synchronous FIFO of fetch_entry_s with push, pop, flush, count, full and empty. Flush has priority over push and pop in the same cycle.

Test Plan:
- Streaming: reset, ready=1, 1-cycle memory returning addr^32'hA5A5_0000 -> decode sees PCs 0,4,8,... in order with matching words; no gaps after warm-up.
- Backpressure: i_instr_ready=0 for 10 cycles -> exactly FIFO_DEPTH requests issued and then o_imem_req_valid=0; release -> the sequence continues with no loss or duplication.
- Redirect with 2 outstanding: redirect to 0x100 -> the next 2 responses are dropped; the first delivered entry is pc=0x100; the FIFO is empty on the redirect cycle.
- Redirect with a response in the same cycle: outstanding=1, rsp_valid=1 -> discard_cnt=0, the response is dropped, and the next delivered entry is the target.
- PC wrap: redirect to FFFF_FFF8 -> delivered PCs are FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Optional feature, macro defined: redirect to 0x102 -> o_fetch_fault=1 and no requests; redirect to 0x200 -> fault clears and fetch resumes at 0x200. Macro undefined: fetch resumes at 0x100.
